// File: rtl/mips_mem_bridge.sv
// Single-port memory bridge between a multicycle MIPS core and block RAM / MMIO registers.
// Latency: RAM load 2 cycles, RAM store / MMIO / fault 1 cycle, request to ready pulse.
// Backpressure: one access in flight; req is only sampled in IDLE, and the CPU holds it until ready.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   req_i, addr_i,      CPU access request, byte address, store data, store select
//   wr_data_i, wr_ena_i
//   ready_o, rd_data_o  one-cycle completion pulse, load/fetch data
//   fault_o             sticky misaligned/unmapped flag
//   ram_*               synchronous block RAM port (read data valid the cycle after the address)
//   sw_in_i, led_out_o  asynchronous switch inputs, LED register
module mips_mem_bridge #(
    parameter int             N         = 32,
    parameter int             RAM_AW    = 10,
    parameter logic [N-1:0]   MMIO_BASE = 32'h8000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [N-1:0]      addr_i,
    input  logic [N-1:0]      wr_data_i,
    input  logic              wr_ena_i,
    output logic              ready_o,
    output logic [N-1:0]      rd_data_o,
    output logic              fault_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [N-1:0]      ram_wr_data_o,
    output logic              ram_wr_ena_o,
    input  logic [N-1:0]      ram_rd_data_i,
    input  logic [15:0]       sw_in_i,
    output logic [15:0]       led_out_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAM_RD = 2'd1,
        RESP   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_LED = 2'd0;
    localparam logic [1:0] SEL_SW  = 2'd1;

    state_t          state_q, state_d;
    logic [N-1:0]    rd_data_q, rd_data_d;
    logic            fault_q, fault_d;
    logic [15:0]     led_q, led_d;
    logic [N-1:0]    cycles_q;
    logic [15:0]     sw_meta_q, sw_sync_q;

    logic            aligned;
    logic            ram_hit;
    logic            mmio_hit;
    logic [N-1:0]    mmio_off;
    logic [1:0]      mmio_sel;

    // Address decode. RAM occupies the bottom 4*2**RAM_AW bytes; MMIO is three words at MMIO_BASE.
    // The offset subtraction wraps for addresses below the base, so a single unsigned compare suffices.
    assign aligned  = (addr_i[1:0] == 2'b00);
    assign ram_hit  = (addr_i[N-1:RAM_AW+2] == '0);
    assign mmio_off = addr_i - MMIO_BASE;
    assign mmio_hit = (mmio_off < N'(12));
    assign mmio_sel = mmio_off[3:2];

    always_comb begin
        state_d       = state_q;
        rd_data_d     = rd_data_q;
        fault_d       = fault_q;
        led_d         = led_q;
        ram_addr_o    = '0;
        ram_wr_data_o = '0;
        ram_wr_ena_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (!aligned || !(ram_hit || mmio_hit)) begin
                        // Response data and the sticky flag are set on entry so they are
                        // already valid while FAULT raises ready.
                        state_d   = FAULT;
                        rd_data_d = N'(32'hDEAD_BEEF);
                        fault_d   = 1'b1;
                    end else if (ram_hit) begin
                        // Address goes to the RAM in the request cycle so its synchronous
                        // read data is available during RAM_RD.
                        ram_addr_o = addr_i[RAM_AW+1:2];
                        if (wr_ena_i) begin
                            ram_wr_ena_o  = 1'b1;
                            ram_wr_data_o = wr_data_i;
                            state_d       = RESP;
                        end else begin
                            state_d = RAM_RD;
                        end
                    end else begin
                        state_d = RESP;
                        if (wr_ena_i) begin
                            // Only the LED register is writable; SW and CYCLES stores complete silently.
                            if (mmio_sel == SEL_LED) begin
                                led_d = wr_data_i[15:0];
                            end
                        end else begin
                            case (mmio_sel)
                                SEL_LED: rd_data_d = {{(N-16){1'b0}}, led_q};
                                SEL_SW:  rd_data_d = {{(N-16){1'b0}}, sw_sync_q};
                                default: rd_data_d = cycles_q;
                            endcase
                        end
                    end
                end
            end
            RAM_RD: begin
                rd_data_d = ram_rd_data_i;
                state_d   = RESP;
            end
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
            fault_q   <= 1'b0;
            led_q     <= '0;
            cycles_q  <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            fault_q   <= fault_d;
            led_q     <= led_d;
            cycles_q  <= cycles_q + 1'b1;
            sw_meta_q <= sw_in_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign ready_o   = (state_q == RESP) || (state_q == FAULT);
    assign rd_data_o = rd_data_q;
    assign fault_o   = fault_q;
    assign led_out_o = led_q;

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Directed testbench for mips_mem_bridge with a synchronous RAM model attached to its RAM port.
// Latency: each access is measured in clock edges from request sampling to ready.
// Backpressure: the driver holds the request until ready, then idles one cycle before the next access.
module tb_mips_mem_bridge;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_ena;
    logic        ready;
    logic [31:0] rd_data;
    logic        fault;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wr_data;
    logic        ram_wr_ena;
    logic [31:0] ram_rd_data;
    logic [15:0] sw_in;
    logic [15:0] led_out;

    int checks;
    int errors;
    int wr_cnt;
    logic [9:0]  last_wr_addr;
    logic [31:0] last_wr_data;

    logic [31:0] mem [0:1023];

    mips_mem_bridge dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .addr_i        (addr),
        .wr_data_i     (wr_data),
        .wr_ena_i      (wr_ena),
        .ready_o       (ready),
        .rd_data_o     (rd_data),
        .fault_o       (fault),
        .ram_addr_o    (ram_addr),
        .ram_wr_data_o (ram_wr_data),
        .ram_wr_ena_o  (ram_wr_ena),
        .ram_rd_data_i (ram_rd_data),
        .sw_in_i       (sw_in),
        .led_out_o     (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM model: 1-cycle synchronous read, write on strobe.
    always @(posedge clk) begin
        if (ram_wr_ena) mem[ram_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_addr];
    end

    // Write strobe monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (ram_wr_ena) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= ram_addr;
            last_wr_data <= ram_wr_data;
        end
    end

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic we,
                          output logic [31:0] rd, output int lat, output logic rdy_after);
        req     = 1'b1;
        addr    = a;
        wr_data = d;
        wr_ena  = we;
        lat     = -1;
        rd      = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i;
                rd  = rd_data;
                break;
            end
        end
        req    = 1'b0;
        wr_ena = 1'b0;
        @(posedge clk); #1;
        rdy_after = ready;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0)        begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (rd_data !== 32'h0)     begin errors++; $display("FAIL reset_rd_data got %h want 00000000", rd_data); end
        checks++; if (fault !== 1'b0)        begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
        checks++; if (led_out !== 16'h0)     begin errors++; $display("FAIL reset_led got %h want 0000", led_out); end
        checks++; if (ram_wr_ena !== 1'b0)   begin errors++; $display("FAIL reset_ram_wr_ena got %b want 0", ram_wr_ena); end
        checks++; if (ram_addr !== 10'h0)    begin errors++; $display("FAIL reset_ram_addr got %h want 000", ram_addr); end
        checks++; if (ram_wr_data !== 32'h0) begin errors++; $display("FAIL reset_ram_wr_data got %h want 00000000", ram_wr_data); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ram_load();
        logic [31:0] rd; int lat; logic ra;
        access(32'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (lat !== 2)            begin errors++; $display("FAIL ram_load_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'h2002_0005) begin errors++; $display("FAIL ram_load_data got %h want 20020005", rd); end
        checks++; if (fault !== 1'b0)       begin errors++; $display("FAIL ram_load_fault got %b want 0", fault); end
        checks++; if (ra !== 1'b0)          begin errors++; $display("FAIL ram_load_ready_pulse got %b want 0", ra); end
    endtask

    task automatic test_ram_store();
        logic [31:0] rd; int lat; logic ra; int w0;
        w0 = wr_cnt;
        access(32'h10, 32'h1234_5678, 1'b1, rd, lat, ra);
        checks++; if (lat !== 1)                   begin errors++; $display("FAIL ram_store_latency got %0d want 1", lat); end
        checks++; if (wr_cnt - w0 !== 1)           begin errors++; $display("FAIL ram_store_strobes got %0d want 1", wr_cnt - w0); end
        checks++; if (last_wr_addr !== 10'd4)      begin errors++; $display("FAIL ram_store_word got %0d want 4", last_wr_addr); end
        checks++; if (last_wr_data !== 32'h1234_5678) begin errors++; $display("FAIL ram_store_wdata got %h want 12345678", last_wr_data); end
        access(32'h10, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (lat !== 2)            begin errors++; $display("FAIL ram_readback_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ram_readback_data got %h want 12345678", rd); end
    endtask

    task automatic test_mmio_led();
        logic [31:0] rd; int lat; logic ra; int w0;
        w0 = wr_cnt;
        access(32'h8000_0000, 32'hABCD_00FF, 1'b1, rd, lat, ra);
        checks++; if (lat !== 1)           begin errors++; $display("FAIL led_store_latency got %0d want 1", lat); end
        checks++; if (led_out !== 16'h00FF) begin errors++; $display("FAIL led_value got %h want 00ff", led_out); end
        access(32'h8000_0000, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (lat !== 1)            begin errors++; $display("FAIL led_load_latency got %0d want 1", lat); end
        checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL led_load_data got %h want 000000ff", rd); end
        // Stores to the read-only registers complete without side effects.
        access(32'h8000_0004, 32'h1111_2222, 1'b1, rd, lat, ra);
        checks++; if (lat !== 1)            begin errors++; $display("FAIL sw_store_latency got %0d want 1", lat); end
        checks++; if (fault !== 1'b0)       begin errors++; $display("FAIL sw_store_fault got %b want 0", fault); end
        checks++; if (led_out !== 16'h00FF) begin errors++; $display("FAIL sw_store_led got %h want 00ff", led_out); end
        checks++; if (wr_cnt !== w0)        begin errors++; $display("FAIL mmio_ram_strobes got %0d want %0d", wr_cnt, w0); end
    endtask

    task automatic test_sw_cycles();
        logic [31:0] rd; int lat; logic ra; logic [31:0] c0;
        sw_in = 16'hA5A5;
        repeat (3) @(posedge clk);
        #1;
        access(32'h8000_0004, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h0000_A5A5) begin errors++; $display("FAIL sw_load_data got %h want 0000a5a5", rd); end
        // First read is sampled at edge E; access returns after E+1, so 8 more idle edges put
        // the second sample at E+10.
        access(32'h8000_0008, 32'h0, 1'b0, rd, lat, ra);
        c0 = rd;
        repeat (8) @(posedge clk);
        #1;
        access(32'h8000_0008, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd - c0 !== 32'd10) begin errors++; $display("FAIL cycles_delta got %0d want 10", rd - c0); end
        checks++; if (fault !== 1'b0)     begin errors++; $display("FAIL cycles_fault got %b want 0", fault); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; int lat; logic ra; int w0;
        w0 = wr_cnt;
        access(32'h0000_0002, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (lat !== 1)            begin errors++; $display("FAIL misaligned_latency got %0d want 1", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misaligned_data got %h want deadbeef", rd); end
        checks++; if (fault !== 1'b1)       begin errors++; $display("FAIL misaligned_fault got %b want 1", fault); end
        access(32'h4000_0000, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (lat !== 1)            begin errors++; $display("FAIL unmapped_latency got %0d want 1", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unmapped_data got %h want deadbeef", rd); end
        // Misaligned store inside RAM and store just past the MMIO window must not write anything.
        access(32'h0000_0006, 32'hFFFF_FFFF, 1'b1, rd, lat, ra);
        access(32'h8000_000C, 32'hFFFF_FFFF, 1'b1, rd, lat, ra);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL past_window_data got %h want deadbeef", rd); end
        checks++; if (wr_cnt !== w0)        begin errors++; $display("FAIL fault_strobes got %0d want %0d", wr_cnt, w0); end
        checks++; if (led_out !== 16'h00FF) begin errors++; $display("FAIL fault_led got %h want 00ff", led_out); end
        checks++; if (mem[0] !== 32'h2002_0005) begin errors++; $display("FAIL fault_ram0 got %h want 20020005", mem[0]); end
        checks++; if (mem[1] !== 32'h0)     begin errors++; $display("FAIL fault_ram1 got %h want 00000000", mem[1]); end
        checks++; if (fault !== 1'b1)       begin errors++; $display("FAIL fault_sticky got %b want 1", fault); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; int lat; logic ra;
        req = 1'b1; addr = 32'h0; wr_ena = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        #1;
        checks++; if (ready !== 1'b0)      begin errors++; $display("FAIL midrst_ready got %b want 0", ready); end
        checks++; if (rd_data !== 32'h0)   begin errors++; $display("FAIL midrst_rd_data got %h want 00000000", rd_data); end
        checks++; if (fault !== 1'b0)      begin errors++; $display("FAIL midrst_fault got %b want 0", fault); end
        checks++; if (led_out !== 16'h0)   begin errors++; $display("FAIL midrst_led got %h want 0000", led_out); end
        checks++; if (ram_wr_ena !== 1'b0) begin errors++; $display("FAIL midrst_ram_wr_ena got %b want 0", ram_wr_ena); end
        @(posedge clk); #1;
        checks++; if (ready !== 1'b0)      begin errors++; $display("FAIL midrst_held_ready got %b want 0", ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        access(32'h10, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (lat !== 2)            begin errors++; $display("FAIL post_rst_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL post_rst_data got %h want 12345678", rd); end
        checks++; if (fault !== 1'b0)       begin errors++; $display("FAIL post_rst_fault got %b want 0", fault); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        wr_cnt  = 0;
        last_wr_addr = '0;
        last_wr_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]  = 32'h2002_0005;
        rst     = 1'b0;
        req     = 1'b0;
        addr    = 32'h0;
        wr_data = 32'h0;
        wr_ena  = 1'b0;
        sw_in   = 16'h0;

        test_reset();
        test_ram_load();
        test_ram_store();
        test_mmio_led();
        test_sw_cycles();
        test_fault();
        test_reset_mid_access();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
